// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared menu state type and button geometry helpers
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        FIRE  = 2'd2,
        LOCK  = 2'd3
    } menu_nav_state;

    // Buttons form one centred column; gaps between buttons equal the button height.
    function automatic int btn_x(input int hor_pix);
        return hor_pix * 2 / 5;
    endfunction

    function automatic int btn_w(input int hor_pix);
        return hor_pix / 5;
    endfunction

    function automatic int btn_h(input int ver_pix, input int n_buttons);
        return ver_pix / (2 * n_buttons + 1);
    endfunction

    function automatic int btn_y(input int ver_pix, input int n_buttons, input int k);
        return ver_pix * (2 * k + 1) / (2 * n_buttons + 1);
    endfunction

endpackage

// File: rtl/menu_hit.sv
// rtl/menu_hit.sv - registered pointer-to-button hit test
// Ports: i_clk, i_rst_n (async, active-low), i_mouse_x/i_mouse_y pointer position,
//        o_hover_valid pointer inside a button, o_hit_idx index of that button.
module menu_hit
    import snake_pkg::*;
#(
    parameter int N_BUTTONS = 3,
    parameter int HOR_PIX   = 1024,
    parameter int VER_PIX   = 768,
    parameter int POS_W     = 12,
    localparam int IDX_W    = $clog2(N_BUTTONS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [POS_W-1:0] i_mouse_x,
    input  logic [POS_W-1:0] i_mouse_y,
    output logic             o_hover_valid,
    output logic [IDX_W-1:0] o_hit_idx
);

    localparam logic [31:0] X_LO = 32'(btn_x(HOR_PIX));
    localparam logic [31:0] X_HI = 32'(btn_x(HOR_PIX) + btn_w(HOR_PIX));
    localparam logic [31:0] H    = 32'(btn_h(VER_PIX, N_BUTTONS));

    logic [31:0]      w_x;
    logic [31:0]      w_y;
    logic [31:0]      w_y_lo;
    logic             w_hover;
    logic [IDX_W-1:0] w_idx;
    logic             r_hover;
    logic [IDX_W-1:0] r_idx;

    // Scan from the top index down so the lowest matching button wins.
    always_comb begin
        w_x     = 32'(i_mouse_x);
        w_y     = 32'(i_mouse_y);
        w_y_lo  = '0;
        w_hover = 1'b0;
        w_idx   = '0;
        for (int k = N_BUTTONS - 1; k >= 0; k--) begin
            w_y_lo = 32'(btn_y(VER_PIX, N_BUTTONS, k));
            if (w_x >= X_LO && w_x < X_HI && w_y >= w_y_lo && w_y < w_y_lo + H) begin
                w_hover = 1'b1;
                w_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hover <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_hover <= w_hover;
            r_idx   <= w_idx;
        end
    end

    assign o_hover_valid = r_hover;
    assign o_hit_idx     = r_idx;

endmodule

// File: rtl/menu_nav.sv
// rtl/menu_nav.sv - mouse/keyboard menu navigation and selection controller
// Ports: i_clk, i_rst_n (async, active-low), i_enable menu active,
//        i_mouse_x/y/left pointer, i_key_up/down/enter keyboard strobes,
//        o_cursor_idx highlighted button, o_hover_valid, o_pressed,
//        o_sel_valid one-cycle selection pulse with o_sel_idx.
module menu_nav
    import snake_pkg::*;
#(
    parameter int N_BUTTONS = 3,
    parameter int HOR_PIX   = 1024,
    parameter int VER_PIX   = 768,
    parameter int POS_W     = 12,
    localparam int IDX_W    = $clog2(N_BUTTONS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [POS_W-1:0] i_mouse_x,
    input  logic [POS_W-1:0] i_mouse_y,
    input  logic             i_mouse_left,
    input  logic             i_key_up,
    input  logic             i_key_down,
    input  logic             i_key_enter,
    output logic [IDX_W-1:0] o_cursor_idx,
    output logic             o_hover_valid,
    output logic             o_pressed,
    output logic             o_sel_valid,
    output logic [IDX_W-1:0] o_sel_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BUTTONS - 1);

    menu_nav_state    r_state;
    menu_nav_state    w_state_nxt;
    logic [IDX_W-1:0] r_cursor;
    logic [IDX_W-1:0] w_cursor_nxt;
    logic [IDX_W-1:0] r_sel_idx;
    logic [IDX_W-1:0] w_sel_nxt;
    logic [IDX_W-1:0] r_pressed_btn;
    logic [IDX_W-1:0] w_pbtn_nxt;
    logic             r_ml_q;
    logic             w_hover;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_ml_rise;
    logic             w_on_pbtn;

    menu_hit #(
        .N_BUTTONS (N_BUTTONS),
        .HOR_PIX   (HOR_PIX),
        .VER_PIX   (VER_PIX),
        .POS_W     (POS_W)
    ) u_hit (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_mouse_x     (i_mouse_x),
        .i_mouse_y     (i_mouse_y),
        .o_hover_valid (w_hover),
        .o_hit_idx     (w_hit_idx)
    );

    // History resets high so a button already held at reset release is not an edge.
    assign w_ml_rise = i_mouse_left & ~r_ml_q;
    assign w_on_pbtn = w_hover && (w_hit_idx == r_pressed_btn);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cursor      <= '0;
            r_sel_idx     <= '0;
            r_pressed_btn <= '0;
            r_ml_q        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cursor      <= w_cursor_nxt;
            r_sel_idx     <= w_sel_nxt;
            r_pressed_btn <= w_pbtn_nxt;
            r_ml_q        <= i_mouse_left;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_sel_nxt    = r_sel_idx;
        w_pbtn_nxt   = r_pressed_btn;
        if (!i_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // Hover overrides any key move in the same cycle.
                    if (w_hover) begin
                        w_cursor_nxt = w_hit_idx;
                    end else if (i_key_up && !i_key_down) begin
                        w_cursor_nxt = (r_cursor == '0) ? LAST_IDX : r_cursor - IDX_W'(1);
                    end else if (i_key_down && !i_key_up) begin
                        w_cursor_nxt = (r_cursor == LAST_IDX) ? '0 : r_cursor + IDX_W'(1);
                    end
                    if (w_ml_rise && w_hover) begin
                        w_state_nxt = PRESS;
                        w_pbtn_nxt  = w_hit_idx;
                    end else if (i_key_enter && !i_mouse_left) begin
                        w_state_nxt = FIRE;
                        w_sel_nxt   = r_cursor;
                    end
                end
                PRESS: begin
                    if (!i_mouse_left) begin
                        if (w_on_pbtn) begin
                            w_state_nxt = FIRE;
                            w_sel_nxt   = r_pressed_btn;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                FIRE: begin
                    w_state_nxt = LOCK;
                end
                LOCK: begin
                    if (!i_mouse_left && !i_key_enter) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_cursor_idx  = r_cursor;
        o_hover_valid = w_hover;
        o_pressed     = (r_state == PRESS) && w_on_pbtn;
        o_sel_valid   = (r_state == FIRE) && i_enable;
        o_sel_idx     = r_sel_idx;
    end

endmodule

// File: tb/tb_menu_nav.sv
// tb/tb_menu_nav.sv - directed scoreboard bench for menu_nav
module tb_menu_nav;

    typedef struct {
        string      tag;
        logic [1:0] cur;
        logic       hov;
        logic       prs;
        logic       sv;
        logic [1:0] sidx;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] mx, my;
    logic        ml, kup, kdn, ken;
    logic [1:0]  cur, sidx;
    logic        hov, prs, sv;

    logic [11:0] mx5, my5;
    logic [2:0]  cur5, sidx5;
    logic        hov5, prs5, sv5;

    always #5 clk = ~clk;

    menu_nav #(.N_BUTTONS(3), .HOR_PIX(1024), .VER_PIX(768), .POS_W(12)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_mouse_x    (mx),
        .i_mouse_y    (my),
        .i_mouse_left (ml),
        .i_key_up     (kup),
        .i_key_down   (kdn),
        .i_key_enter  (ken),
        .o_cursor_idx (cur),
        .o_hover_valid(hov),
        .o_pressed    (prs),
        .o_sel_valid  (sv),
        .o_sel_idx    (sidx)
    );

    menu_nav #(.N_BUTTONS(5), .HOR_PIX(1024), .VER_PIX(768), .POS_W(12)) u_dut5 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (1'b1),
        .i_mouse_x    (mx5),
        .i_mouse_y    (my5),
        .i_mouse_left (1'b0),
        .i_key_up     (1'b0),
        .i_key_down   (1'b0),
        .i_key_enter  (1'b0),
        .o_cursor_idx (cur5),
        .o_hover_valid(hov5),
        .o_pressed    (prs5),
        .o_sel_valid  (sv5),
        .o_sel_idx    (sidx5)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Queue the outputs expected after the next rising edge, then pop and compare mid-cycle.
    task automatic step(input string tag, input logic [1:0] e_cur, input logic e_hov,
                        input logic e_prs, input logic e_sv, input logic [1:0] e_sidx);
        exp_t e;
        q_exp.push_back('{tag, e_cur, e_hov, e_prs, e_sv, e_sidx});
        @(posedge clk);
        @(negedge clk);
        e = q_exp.pop_front();
        chk({e.tag, ".cursor"}, 8'(cur),  8'(e.cur));
        chk({e.tag, ".hover"},  8'(hov),  8'(e.hov));
        chk({e.tag, ".pressed"},8'(prs),  8'(e.prs));
        chk({e.tag, ".sel_vld"},8'(sv),   8'(e.sv));
        chk({e.tag, ".sel_idx"},8'(sidx), 8'(e.sidx));
        kup = 1'b0;
        kdn = 1'b0;
    endtask

    task automatic mouse(input int x, input int y);
        mx = 12'(x);
        my = 12'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1;
        mx = '0; my = '0; ml = 1'b0; kup = 1'b0; kdn = 1'b0; ken = 1'b0;
        mx5 = 12'd500; my5 = 12'd640;
        repeat (2) @(negedge clk);
        step("reset",      2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Hover tracking: cursor lags hover by one cycle
        mouse(500, 150); step("hov_b0",     2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        mouse(500, 330); step("hov_b1_a",   2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("n5.hover", 8'(hov5), 8'd1);
        chk("n5.cursor", 8'(cur5), 8'd4);
        step("hov_b1_b",   2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        mouse(300, 330); step("off_a",      2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        step("off_b",      2'd1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Click on button 2
        mouse(500, 560); step("to_b2",      2'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        ml = 1'b1;       step("press_a",    2'd2, 1'b1, 1'b1, 1'b0, 2'd0);
        step("press_b",    2'd2, 1'b1, 1'b1, 1'b0, 2'd0);
        ml = 1'b0;       step("fire",       2'd2, 1'b1, 1'b0, 1'b1, 2'd2);
        step("fire_once",  2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
        step("unlock",     2'd2, 1'b1, 1'b0, 1'b0, 2'd2);

        // Drag off the pressed button and release: aborted
        ml = 1'b1;       step("drag_prs",   2'd2, 1'b1, 1'b1, 1'b0, 2'd2);
        mouse(500, 150); step("drag_off",   2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
        ml = 1'b0;       step("drag_rel",   2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
        step("drag_idle",  2'd0, 1'b1, 1'b0, 1'b0, 2'd2);

        // Keyboard navigation and enter
        mouse(300, 330); step("kb_off",     2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        kup = 1'b1;      step("key_up_wrap",2'd2, 1'b0, 1'b0, 1'b0, 2'd2);
        kdn = 1'b1;      step("key_dn_wrap",2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        kup = 1'b1; kdn = 1'b1; step("key_both", 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        ken = 1'b1;      step("enter",      2'd0, 1'b0, 1'b0, 1'b1, 2'd0);
        step("enter_h1",   2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        step("enter_h2",   2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        step("enter_h3",   2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        ken = 1'b0;      step("enter_rel",  2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        kdn = 1'b1;      step("key_dn",     2'd1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Disable keeps cursor and forces FIRE back to IDLE
        enable = 1'b0; kdn = 1'b1; step("dis_keep", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        enable = 1'b1; ken = 1'b1; step("en_fire",  2'd1, 1'b0, 1'b0, 1'b1, 2'd1);
        enable = 1'b0; ken = 1'b0; step("dis_fire", 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        enable = 1'b1; kdn = 1'b1; step("dis_idle", 2'd2, 1'b0, 1'b0, 1'b0, 2'd1);

        // Reset in the middle of a press, released with the button still held
        mouse(500, 560); step("rp_hover",   2'd2, 1'b1, 1'b0, 1'b0, 2'd1);
        ml = 1'b1;       step("rp_press",   2'd2, 1'b1, 1'b1, 1'b0, 2'd1);
        rst_n = 1'b0;    step("rp_reset",   2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;    step("rp_held",    2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        ml = 1'b0;       step("rp_rel",     2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        step("rp_quiet",   2'd2, 1'b1, 1'b0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
